// File: rtl/pong_pkg.sv
// Shared Pong geometry, ball state encoding and direction encoding.
package pong_pkg;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned BALL_SIZE  = 8;
  localparam int unsigned PADDLE_L_X = 20;
  localparam int unsigned PADDLE_R_X = 612;
  localparam int unsigned PADDLE_W   = 8;
  localparam int unsigned PADDLE_LEN = 64;

  // Width of internal position arithmetic; one bit of headroom over the 10-bit ports.
  localparam int unsigned PosW = 11;

  typedef enum logic [1:0] {
    StServe,
    StPlay,
    StPoint,
    StHalt
  } ball_state_e;

  // DirInc is right for x and down for y.
  typedef enum logic {
    DirInc = 1'b0,
    DirDec = 1'b1
  } dir_e;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle tick when vcount first reaches TickLine, regardless of pixel clock ratio.
module frame_tick_gen
  import pong_pkg::*;
#(
  parameter int unsigned TickLine = SCREEN_H
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] vcount_i,
  output logic       tick_o
);

  localparam logic [9:0] TickVal = 10'(TickLine);

  logic [9:0] vcount_prev_q;
  logic       tick_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vcount_prev_q <= '0;
      tick_q        <= 1'b0;
    end else begin
      vcount_prev_q <= vcount_i;
      tick_q        <= (vcount_i == TickVal) && (vcount_prev_q != TickVal);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: per-frame motion, wall/paddle bounces, miss detection and ball pixel.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SPEED_X      = 2,
  parameter int unsigned SPEED_Y      = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned START_X      = 316,
  parameter int unsigned START_Y      = 236
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  input  logic       game_over,
  output logic       score_pulse_l,
  output logic       score_pulse_r,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       r,
  output logic       g,
  output logic       b
);

  localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

  localparam logic [PosW-1:0] ScrW   = PosW'(SCREEN_W);
  localparam logic [PosW-1:0] ScrH   = PosW'(SCREEN_H);
  localparam logic [PosW-1:0] Ball   = PosW'(BALL_SIZE);
  localparam logic [PosW-1:0] LFace  = PosW'(PADDLE_L_X + PADDLE_W);
  localparam logic [PosW-1:0] RFace  = PosW'(PADDLE_R_X);
  localparam logic [PosW-1:0] PadLen = PosW'(PADDLE_LEN);
  localparam logic [PosW-1:0] SpX    = PosW'(SPEED_X);
  localparam logic [PosW-1:0] SpY    = PosW'(SPEED_Y);
  localparam logic [9:0]      StartX = 10'(START_X);
  localparam logic [9:0]      StartY = 10'(START_Y);

  ball_state_e     state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  dir_e            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_l_q, pulse_l_d, pulse_r_q, pulse_r_d;
  logic            frame_tick;

  logic [PosW-1:0] x_ext, y_ext, pl_ext, pr_ext, h_ext, v_ext;
  logic            l_ovl, r_ovl, l_hit, r_hit, l_miss, r_miss, pix_on;

  frame_tick_gen #(
    .TickLine (SCREEN_H)
  ) u_frame_tick_gen (
    .clk_i    (clk),
    .reset_i  (reset),
    .vcount_i (vcount),
    .tick_o   (frame_tick)
  );

  // All comparisons are arranged so no operand is ever subtracted below zero.
  always_comb begin
    x_ext  = {1'b0, x_q};
    y_ext  = {1'b0, y_q};
    pl_ext = {1'b0, paddle_l_y};
    pr_ext = {1'b0, paddle_r_y};
    l_ovl  = (y_ext + Ball > pl_ext) && (y_ext < pl_ext + PadLen);
    r_ovl  = (y_ext + Ball > pr_ext) && (y_ext < pr_ext + PadLen);
    l_hit  = (dir_x_q == DirDec) && (x_ext >= LFace) && (x_ext <= LFace + SpX) && l_ovl;
    r_hit  = (dir_x_q == DirInc) && (x_ext + Ball <= RFace) && (x_ext + SpX + Ball >= RFace)
             && r_ovl;
    l_miss = (dir_x_q == DirDec) && (x_ext < SpX);
    r_miss = (dir_x_q == DirInc) && (x_ext + SpX + Ball > ScrW);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    cnt_d     = cnt_q;
    pulse_l_d = 1'b0;
    pulse_r_d = 1'b0;
    if (game_over) begin
      state_d = StHalt;
      x_d     = StartX;
      y_d     = StartY;
    end else begin
      unique case (state_q)
        StServe: begin
          x_d = StartX;
          y_d = StartY;
          if (frame_tick) begin
            if (cnt_q == CntW'(SERVE_FRAMES - 1)) begin
              state_d = StPlay;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StPlay: begin
          if (frame_tick) begin
            if (dir_y_q == DirInc) begin
              if (y_ext + SpY + Ball >= ScrH) begin
                y_d     = 10'(ScrH - Ball);
                dir_y_d = DirDec;
              end else begin
                y_d = 10'(y_ext + SpY);
              end
            end else if (y_ext < SpY) begin
              y_d     = '0;
              dir_y_d = DirInc;
            end else begin
              y_d = 10'(y_ext - SpY);
            end

            if (l_hit) begin
              x_d     = 10'(LFace);
              dir_x_d = DirInc;
            end else if (r_hit) begin
              x_d     = 10'(RFace - Ball);
              dir_x_d = DirDec;
            end else if (l_miss) begin
              pulse_r_d = 1'b1;
              state_d   = StPoint;
            end else if (r_miss) begin
              pulse_l_d = 1'b1;
              state_d   = StPoint;
            end else if (dir_x_q == DirInc) begin
              x_d = 10'(x_ext + SpX);
            end else begin
              x_d = 10'(x_ext - SpX);
            end
          end
        end
        StPoint: begin
          // Serve toward whoever conceded: a left score means the right side lost.
          x_d     = StartX;
          y_d     = StartY;
          dir_x_d = pulse_l_q ? DirInc : DirDec;
          dir_y_d = DirInc;
          cnt_d   = '0;
          state_d = StServe;
        end
        StHalt: begin
          x_d = StartX;
          y_d = StartY;
        end
        default: state_d = StHalt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StServe;
      x_q       <= StartX;
      y_q       <= StartY;
      dir_x_q   <= DirInc;
      dir_y_q   <= DirInc;
      cnt_q     <= '0;
      pulse_l_q <= 1'b0;
      pulse_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      cnt_q     <= cnt_d;
      pulse_l_q <= pulse_l_d;
      pulse_r_q <= pulse_r_d;
    end
  end

  always_comb begin
    h_ext  = {1'b0, hcount};
    v_ext  = {1'b0, vcount};
    pix_on = (h_ext >= x_ext) && (h_ext < x_ext + Ball) &&
             (v_ext >= y_ext) && (v_ext < y_ext + Ball) && (state_q != StHalt);
  end

  assign score_pulse_l = pulse_l_q && (state_q != StHalt);
  assign score_pulse_r = pulse_r_q && (state_q != StHalt);
  assign ball_x        = x_q;
  assign ball_y        = y_q;
  assign r             = pix_on;
  assign g             = pix_on;
  assign b             = pix_on;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: serve timing, wall clamp, paddle hit, misses, halt, pixel.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount, paddle_l_y, paddle_r_y;
  logic       game_over;
  logic       score_pulse_l, score_pulse_r;
  logic [9:0] ball_x, ball_y;
  logic       r, g, b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pl = 0, n_pr = 0, n_both = 0, n_consec = 0;
  logic prev_any = 1'b0;

  always #5 clk = ~clk;

  ball_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .hcount        (hcount),
    .vcount        (vcount),
    .paddle_l_y    (paddle_l_y),
    .paddle_r_y    (paddle_r_y),
    .game_over     (game_over),
    .score_pulse_l (score_pulse_l),
    .score_pulse_r (score_pulse_r),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .r             (r),
    .g             (g),
    .b             (b)
  );

  // Pulse history, sampled mid-cycle.
  always @(negedge clk) begin
    if (score_pulse_l) n_pl <= n_pl + 1;
    if (score_pulse_r) n_pr <= n_pr + 1;
    if (score_pulse_l && score_pulse_r) n_both <= n_both + 1;
    if ((score_pulse_l || score_pulse_r) && prev_any) n_consec <= n_consec + 1;
    prev_any <= score_pulse_l || score_pulse_r;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check_eq({tag, ".x"}, 32'(ball_x), 32'(x));
    check_eq({tag, ".y"}, 32'(ball_y), 32'(y));
  endtask

  task automatic check_pix(input string tag, input int h, input int v, input int exp);
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    #1;
    check_eq(tag, 32'({r, g, b}), exp != 0 ? 32'd7 : 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    vcount = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge after the FSM has consumed the tick.
  task automatic tick();
    @(negedge clk) vcount = 10'd0;
    @(negedge clk) vcount = 10'd480;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset      = 1'b1;
    hcount     = '0;
    vcount     = '0;
    paddle_l_y = 10'd1000;
    paddle_r_y = 10'd400;
    game_over  = 1'b0;

    // Serve and first moves.
    do_reset();
    check_pos("rst", 316, 236);
    check_eq("rst.pl", 32'(score_pulse_l), 0);
    check_eq("rst.pr", 32'(score_pulse_r), 0);
    check_pix("pix.tl", 316, 236, 1);
    check_pix("pix.br", 323, 243, 1);
    check_pix("pix.right", 324, 243, 0);
    check_pix("pix.below", 323, 244, 0);
    check_pix("pix.left", 315, 236, 0);
    check_pix("pix.above", 316, 235, 0);
    ticks(59);
    check_pos("serve59", 316, 236);
    ticks(1);
    check_pos("serve60", 316, 236);
    check_eq("serve.pulses", 32'(n_pl + n_pr), 0);
    ticks(1);
    check_pos("play1", 318, 238);

    // Bottom wall clamp.
    ticks(116);
    check_pos("k117", 550, 470);
    ticks(1);
    check_pos("clamp", 552, 472);
    ticks(1);
    check_pos("after_clamp", 554, 470);

    // Right paddle hit with paddle_r_y=400, pre-move y=422.
    ticks(24);
    check_pos("k143", 602, 422);
    check_pix("pix.play_in", 609, 429, 1);
    check_pix("pix.play_out", 610, 429, 0);
    ticks(1);
    check_pos("rhit", 604, 420);
    check_eq("rhit.pulses", 32'(n_pl + n_pr), 0);
    ticks(1);
    check_pos("rhit.dir", 602, 418);

    // Top wall, then off-screen left paddle lets the ball through.
    ticks(209);
    check_pos("top", 184, 0);
    ticks(1);
    check_pos("top.flip", 182, 0);
    ticks(1);
    check_pos("top.down", 180, 2);
    ticks(90);
    check_pos("left_edge", 0, 182);

    // game_over lands on the same edge as the left miss.
    @(negedge clk) vcount = 10'd0;
    @(negedge clk) vcount = 10'd480;
    @(negedge clk) game_over = 1'b1;
    @(negedge clk);
    check_eq("go.pr", 32'(score_pulse_r), 0);
    check_eq("go.pl", 32'(score_pulse_l), 0);
    @(negedge clk);
    check_eq("go.pr2", 32'(score_pulse_r), 0);
    check_pos("halt", 316, 236);
    check_pix("halt.pix0", 316, 236, 0);
    check_pix("halt.pix1", 320, 240, 0);
    ticks(2);
    check_pos("halt.frozen", 316, 236);
    game_over = 1'b0;
    ticks(1);
    check_pix("halt.sticky", 316, 236, 0);
    check_eq("go.npulses", 32'(n_pl + n_pr), 0);
    do_reset();
    check_pos("rst2", 316, 236);
    check_pix("rst2.pix", 316, 236, 1);

    // Right miss with the right paddle far from the ball.
    paddle_r_y = 10'd0;
    ticks(60);
    ticks(158);
    check_pos("k158", 632, 392);
    ticks(1);
    check_eq("miss.pl", 32'(score_pulse_l), 1);
    check_eq("miss.pr", 32'(score_pulse_r), 0);
    @(negedge clk);
    check_eq("miss.pl_off", 32'(score_pulse_l), 0);
    check_pos("point", 316, 236);
    ticks(59);
    check_pos("reserve59", 316, 236);
    ticks(1);
    check_pos("reserve60", 316, 236);
    ticks(1);
    check_pos("replay1", 318, 238);
    check_eq("cnt.pl", 32'(n_pl), 1);
    check_eq("cnt.pr", 32'(n_pr), 0);
    check_eq("cnt.both", 32'(n_both), 0);
    check_eq("cnt.consec", 32'(n_consec), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
